// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the SRAM slave state type.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } slave_state_t;

endpackage

// File: rtl/ahb_byte_lane.sv
// Decodes transfer size and low address bits into a byte-enable mask and
// an alignment error flag. Sizes above a word yield an empty mask.
module ahb_byte_lane
   import ahb_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] byte_en,
   output logic       misalign
);

   // Size/offset to lane mask; half-words use the upper pair when addr_lo[1] is set.
   always_comb begin
      byte_en  = 4'b0000;
      misalign = 1'b0;
      case (size)
         HSIZE_BYTE: byte_en = 4'b0001 << addr_lo;
         HSIZE_HALF: begin
            byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
            misalign = addr_lo[0];
         end
         HSIZE_WORD: begin
            byte_en  = 4'b1111;
            misalign = (addr_lo != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable wait states and two-cycle ERROR.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no stalled data phase; a zero-wait OKAY data phase may be active
// WAIT    | OKAY data phase stalling; completes when the counter reaches 0
// ERR1    | first ERROR cycle, hreadyout low
// ERR2    | second ERROR cycle, hreadyout high
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 0,
   parameter int INIT_ZERO   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [31:0] hwdata,
   input  logic        hready_in,
   output logic [31:0] hrdata,
   output logic        hreadyout,
   output logic        hresp
);

   localparam int         AW        = $clog2(DEPTH_WORDS);
   localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

   slave_state_t    state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            act_q, act_d;
   logic            write_q, write_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [3:0]      be_q, be_d;
   logic [31:0]     mem_q [DEPTH_WORDS];

   logic [3:0]      be_addr;
   logic            misalign;
   logic            accept;
   logic            addr_err;
   logic            ready;
   logic            commit;
   logic            unused_haddr;

   assign unused_haddr = ^haddr[31:AW+2];

   ahb_byte_lane u_byte_lane (
      .size     (hsize),
      .addr_lo  (haddr[1:0]),
      .byte_en  (be_addr),
      .misalign (misalign)
   );

   assign accept   = hsel && hready_in &&
                     ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
   assign addr_err = (hsize > HSIZE_WORD) || misalign;

   // Outputs depend only on registered state, so they are glitch-free per cycle.
   assign ready     = !((state_q == ST_ERR1) || ((state_q == ST_WAIT) && (cnt_q != 3'd0)));
   assign hreadyout = ready;
   assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign commit    = act_q && ready && write_q;
   // Reads are served straight from the array, so a write committed on the
   // previous edge is already visible to a back-to-back read of the same word.
   assign hrdata    = (act_q && ready && !write_q) ? mem_q[idx_q] : 32'h0;

   // Next-state: stall while not ready, otherwise finish and optionally capture a new address phase.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      write_d = write_q;
      idx_d   = idx_q;
      be_d    = be_q;
      if (!ready) begin
         if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
         end else begin
            cnt_d = cnt_q - 3'd1;
         end
      end else begin
         state_d = ST_IDLE;
         act_d   = 1'b0;
         cnt_d   = 3'd0;
         if (accept) begin
            write_d = hwrite;
            idx_d   = haddr[AW+1:2];
            be_d    = be_addr;
            if (addr_err) begin
               state_d = ST_ERR1;
            end else begin
               act_d = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
      end
   end

   // Control registers; reset drops any in-flight transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         act_q   <= 1'b0;
         write_q <= 1'b0;
         idx_q   <= '0;
         be_q    <= 4'b0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         act_q   <= act_d;
         write_q <= write_d;
         idx_q   <= idx_d;
         be_q    <= be_d;
      end
   end

   // Storage: optional clear on reset, masked byte writes on the completing data cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (INIT_ZERO != 0) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
               mem_q[i] <= 32'h0;
            end
         end
      end else if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
               mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
         end
      end
   end

endmodule
